wptr_full: RTL and testbench
============================

Name: wptr_full

Overview:
- Write-side pointer and full-flag logic of the asynchronous FIFO, running entirely in the write clock domain.
- Keeps the binary write address for the dual-port RAM.
- Publishes the Gray-coded write pointer for the 2-flop synchroniser into the read domain.
- Takes the already-synchronised Gray read pointer and produces registered full, almost-full, fill-level and sticky overflow status.

Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth = 2**ADDRSIZE; legal range ADDRSIZE >= 2.
- AFULL_THRESH, 2**ADDRSIZE-2, level at or above which wafull asserts; legal range 1..2**ADDRSIZE.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  active-low reset; synchronous to wclk.
- winc  input  1  write request for this cycle.
- wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronised into wclk.
- wclr_ovf  input  1  clears woverflow.
- waddr  output  ADDRSIZE  RAM write address.
- wptr  output  ADDRSIZE+1  registered Gray write pointer, to the read-domain synchroniser.
- wfull  output  1  FIFO full; registered.
- wafull  output  1  almost full; registered.
- wlevel  output  ADDRSIZE+1  conservative occupancy, range 0..2**ADDRSIZE; registered.
- woverflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset:
  - Single clock, wclk; reset is synchronous and active-low on wrst_n.
  - Reset is sampled only at the wclk rising edge and dominates every other input.
  - Reset values: wbin=0, wptr=0, wfull=0, wafull=0, wlevel=0, woverflow=0.
  - Reset asserted mid-operation (including while full) zeroes all state at the next edge; no write is accepted on that edge.
- Accept:
  - wen = winc & ~wfull.
  - wbinnext = wbin + wen, modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - Each edge: wbin<=wbinnext, wptr<=wgraynext.
  - waddr = wbin[ADDRSIZE-1:0], combinational from the register.
  - Writes while full are dropped: pointers hold.
- Latency: a write accepted in cycle N appears on wptr/waddr after edge N. wptr changes by exactly one Gray bit per accepted write.
- Full:
  - wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull<=wfull_val, so wfull rises on the same edge as the write that fills the FIFO.
  - wfull deasserts one edge after wq2_rptr advances.
- Level:
  - rbin_s = Gray-to-binary(wq2_rptr).
  - wlevel<=(wbinnext - rbin_s) modulo 2**(ADDRSIZE+1).
  - Never under-reports, because the read pointer lags.
- Almost full: wafull<=(level_next >= AFULL_THRESH) | wfull_val, where level_next is the value being loaded into wlevel.
- Overflow: woverflow<=(winc & wfull) | (woverflow & ~wclr_ovf). Set wins over a simultaneous clear.
- Wrap-around:
  - Binary and Gray pointers wrap naturally at 2**(ADDRSIZE+1); waddr wraps at 2**ADDRSIZE.
  - Full/level comparisons are correct across the wrap with no special casing.
- Simultaneous winc and read-pointer advance while full: the write is refused this cycle; it can be accepted the cycle after wfull clears.

Decomposition:
- Package fifo_pkg holds:
  - function bin2gray(n) and function gray2bin(g), parameterised by width.
  - localparam helpers DEPTH = 2**ADDRSIZE and PTRW = ADDRSIZE+1.
- One sub-module: gray2bin_conv (purely combinational XOR prefix chain), instantiated on wq2_rptr. It is reusable by the read side for a read-level output.

Test Plan (ADDRSIZE=4, AFULL_THRESH=14):
- Reset: wrst_n=0 for 2 edges with winc=1 -> all outputs 0, waddr=0. After release with winc=0 -> outputs stay 0.
- Fill with wq2_rptr=0: 16 consecutive winc pulses -> wptr sequences bin2gray(1..16), last value 5'b11000, waddr 15 -> 0.
  - wafull rises on the edge of the 14th write.
  - wfull rises on the edge of the 16th write; wlevel=16.
- Overflow while full: winc=1 for 1 cycle -> wptr stays 5'b11000, woverflow=1.
  - wclr_ovf=1 alone -> woverflow=0.
  - winc=1 and wclr_ovf=1 together -> woverflow=1.
- Drain: with full at wbin=16, drive wq2_rptr=bin2gray(4)=5'b00110 -> next edge wfull=0, wlevel=12, wafull=0.
  - One more write -> wlevel=13; a second write -> wlevel=14, wafull=1.
- Wrap:
  - Advance to wbin=31 (wptr=5'b10000) with wq2_rptr tracking; one write -> wptr=5'b00000, waddr=0.
  - Then hold rptr at binary 20 (5'b11110) and write to binary 36 -> wptr=5'b00110, wfull=1, wlevel=16.
- Reset mid-operation: assert wrst_n=0 while full and woverflow=1 -> next edge all outputs 0. The first write after release gives wptr=5'b00001.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic.
// Gray/binary conversion and default geometry.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int DEPTH = 2**ADDRSIZE_DEF;
  localparam int PTRW = ADDRSIZE_DEF + 1;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] n
  );
    return n ^ (n >> 1);
  endfunction

  // Bits at or above w are ignored; result fits in w bits.
  function automatic logic [31:0] gray2bin(
    input logic [31:0] g,
    input int          w
  );
    logic [31:0] gm;
    logic [31:0] b;
    gm = g & ((32'h1 << w) - 32'h1);
    b = '0;
    b[31] = gm[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = gm[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter.
// XOR prefix chain from the MSB down.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin[W-1] = gray[W-1];

  for (genvar i = W - 2; i >= 0; i--) begin : g_chain
    assign bin[i] = gray[i] ^ bin[i+1];
  end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer, full, almost-full, level
// and sticky overflow logic of the async FIFO.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wclr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] rptr_full;
  logic [PW-1:0] level_next;
  logic          wen;
  logic          wfull_val;
  logic          wafull_val;

  gray2bin_conv #(
    .W(PW)
  ) u_rconv (
    .gray(wq2_rptr),
    .bin (rbin_s)
  );

  assign wen       = winc & ~wfull;
  assign wbinnext  = wbin + PW'(wen);
  assign wgraynext = PW'(bin2gray(32'(wbinnext)));

  // Full: write pointer one lap ahead of the read pointer.
  assign rptr_full = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                      wq2_rptr[ADDRSIZE-2:0]};
  assign wfull_val = (wgraynext == rptr_full);

  assign level_next = wbinnext - rbin_s;
  assign wafull_val =
    ({1'b0, level_next} >= (PW+1)'(AFULL_THRESH))
    | wfull_val;

  assign waddr = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      wafull    <= 1'b0;
      wlevel    <= '0;
      woverflow <= 1'b0;
    end else begin
      wbin      <= wbinnext;
      wptr      <= wgraynext;
      wfull     <= wfull_val;
      wafull    <= wafull_val;
      wlevel    <= level_next;
      woverflow <= (winc & wfull) | (woverflow & ~wclr_ovf);
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (ADDRSIZE=4).
// Table vectors, directed corners, random vs model.
module tb_wptr_full;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wclr_ovf;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       wafull;
  logic [4:0] wlevel;
  logic       woverflow;

  int checks = 0;
  int errors = 0;

  wptr_full #(
    .ADDRSIZE    (4),
    .AFULL_THRESH(14)
  ) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .wclr_ovf (wclr_ovf),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wafull   (wafull),
    .wlevel   (wlevel),
    .woverflow(woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    bit rst_n;
    bit inc;
    int rb;
    bit clr;
    int addr;
    int ptr;
    bit full;
    bit af;
    int lvl;
    bit ovf;
  } vec_t;

  vec_t tv[$];

  // Reference model: occupancy arithmetic on integer pointers.
  int m_wb;
  bit m_full;
  bit m_af;
  int m_lvl;
  bit m_ovf;

  function automatic int gray(input int n);
    return (n ^ (n >> 1)) & 31;
  endfunction

  function automatic vec_t mk(
    input bit rst_n, input bit inc, input int rb,
    input bit clr, input int addr, input int ptr,
    input bit full, input bit af, input int lvl,
    input bit ovf
  );
    vec_t v;
    v.rst_n = rst_n; v.inc = inc; v.rb = rb;
    v.clr = clr; v.addr = addr; v.ptr = ptr;
    v.full = full; v.af = af; v.lvl = lvl;
    v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst_n,
                            input bit inc,
                            input int rb,
                            input bit clr);
    bit fullp;
    int nb;
    if (!rst_n) begin
      m_wb = 0; m_full = 0; m_af = 0;
      m_lvl = 0; m_ovf = 0;
    end else begin
      fullp = m_full;
      nb = (m_wb + ((inc && !fullp) ? 1 : 0)) % 32;
      m_lvl = (((nb - rb) % 32) + 32) % 32;
      m_full = (m_lvl == 16);
      m_af = (m_lvl >= 14) || m_full;
      m_ovf = (inc && fullp) || (m_ovf && !clr);
      m_wb = nb;
    end
  endtask

  task automatic step(input string tag,
                      input bit rst_n, input bit inc,
                      input int rb, input bit clr);
    wrst_n = rst_n;
    winc = inc;
    wq2_rptr = 5'(gray(rb % 32));
    wclr_ovf = clr;
    @(posedge wclk);
    #1;
    model_step(rst_n, inc, rb % 32, clr);
    chk({tag, ".waddr"}, 32'(waddr), 32'(m_wb % 16));
    chk({tag, ".wptr"}, 32'(wptr), 32'(gray(m_wb)));
    chk({tag, ".wfull"}, 32'(wfull), 32'(m_full));
    chk({tag, ".wafull"}, 32'(wafull), 32'(m_af));
    chk({tag, ".wlevel"}, 32'(wlevel), 32'(m_lvl));
    chk({tag, ".wovf"}, 32'(woverflow), 32'(m_ovf));
  endtask

  initial begin
    int rb;
    int occ;
    wrst_n = 1'b0;
    winc = 1'b0;
    wq2_rptr = '0;
    wclr_ovf = 1'b0;
    m_wb = 0; m_full = 0; m_af = 0;
    m_lvl = 0; m_ovf = 0;

    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 16; i++)
      tv.push_back(mk(1, 1, 0, 0, i % 16, gray(i),
                      i == 16, i >= 14, i, 0));
    tv.push_back(mk(1, 1, 0, 0, 0, 5'b11000, 1, 1, 16, 1));
    tv.push_back(mk(1, 0, 0, 1, 0, 5'b11000, 1, 1, 16, 0));
    tv.push_back(mk(1, 1, 0, 1, 0, 5'b11000, 1, 1, 16, 1));
    tv.push_back(mk(1, 0, 4, 1, 0, 5'b11000, 0, 0, 12, 0));
    tv.push_back(mk(1, 1, 4, 0, 1, 5'b11001, 0, 0, 13, 0));
    tv.push_back(mk(1, 1, 4, 0, 2, 5'b11011, 0, 1, 14, 0));

    foreach (tv[k]) begin
      step("tbl", tv[k].rst_n, tv[k].inc, tv[k].rb, tv[k].clr);
      chk("tv.waddr", 32'(waddr), 32'(tv[k].addr));
      chk("tv.wptr", 32'(wptr), 32'(tv[k].ptr));
      chk("tv.wfull", 32'(wfull), 32'(tv[k].full));
      chk("tv.wafull", 32'(wafull), 32'(tv[k].af));
      chk("tv.wlevel", 32'(wlevel), 32'(tv[k].lvl));
      chk("tv.wovf", 32'(woverflow), 32'(tv[k].ovf));
    end

    // Wrap: wbin 18 -> 31, read side tracking up to 20.
    for (int b = 18; b < 31; b++)
      step("wrap", 1, 1, (b < 20) ? b : 20, 0);
    chk("wrap.wptr31", 32'(wptr), 32'h10);
    step("wrap", 1, 1, 20, 0);
    chk("wrap.wptr0", 32'(wptr), 32'h00);
    chk("wrap.waddr0", 32'(waddr), 32'h0);
    for (int b = 0; b < 4; b++)
      step("wrap", 1, 1, 20, 0);
    chk("wrap.wptr36", 32'(wptr), 32'h06);
    chk("wrap.full", 32'(wfull), 32'h1);
    chk("wrap.level", 32'(wlevel), 32'h10);

    // Overflow then reset while full.
    step("mid", 1, 1, 20, 0);
    chk("mid.ovf", 32'(woverflow), 32'h1);
    step("mid", 0, 1, 20, 0);
    chk("mid.rst_ptr", 32'(wptr), 32'h0);
    chk("mid.rst_full", 32'(wfull), 32'h0);
    chk("mid.rst_ovf", 32'(woverflow), 32'h0);
    step("mid", 1, 1, 0, 0);
    chk("mid.first", 32'(wptr), 32'h01);

    // Random traffic with a lagging, legal read pointer.
    rb = 0;
    for (int n = 0; n < 600; n++) begin
      occ = (((m_wb - rb) % 32) + 32) % 32;
      if (occ > 0 && ($urandom % 3 == 0))
        rb = (rb + 1) % 32;
      if ($urandom % 150 == 0) begin
        step("rnd", 0, $urandom % 2, rb, 0);
        rb = 0;
      end else begin
        step("rnd", 1, ($urandom % 4) != 0, rb,
             ($urandom % 8) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
